acc_cpu_core: RTL and testbench

Parametrised accumulator CPU core, successor to the fixed 8-bit/4-bit-address tiny CPU.
- Generic data and address widths, 16-opcode ISA, carry/zero flags, conditional jumps, halt state.
- Ready-handshaked instruction and data memory ports, so ROM/RAM models with wait states work unchanged.
- Sits between the system top, the rom and the ram, in place of the original core.

---
 rtl/cpu_pkg.sv | 34 +++
 rtl/acc_cpu_core_if.sv | 35 +++
 rtl/cpu_alu.sv | 50 +++++
 rtl/acc_cpu_core.sv | 146 ++++++++++++++
 tb/tb_acc_cpu_core.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the accumulator CPU: opcodes, FSM states, word-width helper.
package cpu_pkg;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_STA = 4'h2;
    localparam logic [3:0] OP_ADD = 4'h3;
    localparam logic [3:0] OP_SUB = 4'h4;
    localparam logic [3:0] OP_AND = 4'h5;
    localparam logic [3:0] OP_OR  = 4'h6;
    localparam logic [3:0] OP_XOR = 4'h7;
    localparam logic [3:0] OP_LDI = 4'h8;
    localparam logic [3:0] OP_JMP = 4'h9;
    localparam logic [3:0] OP_JZ  = 4'hA;
    localparam logic [3:0] OP_JC  = 4'hB;
    localparam logic [3:0] OP_NOT = 4'hC;
    localparam logic [3:0] OP_SHL = 4'hD;
    localparam logic [3:0] OP_SHR = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [2:0] {
        RST_S = 3'd0,
        FETCH = 3'd1,
        EXEC  = 3'd2,
        MEM   = 3'd3,
        HALT  = 3'd4
    } state_t;

    // Instruction word is opcode (MSBs) followed by the address/immediate field.
    function automatic int instr_w(input int opc_w, input int addr_w);
        return opc_w + addr_w;
    endfunction

endpackage

// File: rtl/acc_cpu_core_if.sv
// Instruction and data memory bus of the accumulator CPU, ready-handshaked.
interface acc_cpu_core_if
    import cpu_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int OPC_W  = 4
);
    localparam int IW = instr_w(OPC_W, ADDR_W);

    logic              imem_rd;
    logic [ADDR_W-1:0] imem_addr;
    logic [IW-1:0]     imem_data;
    logic              imem_rdy;
    logic              dmem_rd;
    logic              dmem_wr;
    logic [ADDR_W-1:0] dmem_addr;
    logic [DATA_W-1:0] dmem_wdata;
    logic [DATA_W-1:0] dmem_rdata;
    logic              dmem_rdy;

    modport master (
        output imem_rd, imem_addr,
        input  imem_data, imem_rdy,
        output dmem_rd, dmem_wr, dmem_addr, dmem_wdata,
        input  dmem_rdata, dmem_rdy
    );

    modport slave (
        input  imem_rd, imem_addr,
        output imem_data, imem_rdy,
        input  dmem_rd, dmem_wr, dmem_addr, dmem_wdata,
        output dmem_rdata, dmem_rdy
    );
endinterface

// File: rtl/cpu_alu.sv
// Combinational ALU: computes the new accumulator and carry for every acc-writing opcode.
module cpu_alu
    import cpu_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [3:0]        op,
    input  logic [DATA_W-1:0] acc,
    input  logic [DATA_W-1:0] operand,
    input  logic              c_in,
    output logic [DATA_W-1:0] result,
    output logic              c_out,
    output logic              z_out
);
    logic [DATA_W:0] sum;

    // Opcode-selected result; carry passes through unless the op defines it.
    always_comb begin
        result = acc;
        c_out  = c_in;
        sum    = {(DATA_W+1){1'b0}};
        case (op)
            OP_LDA, OP_LDI: result = operand;
            OP_ADD: begin
                sum    = {1'b0, acc} + {1'b0, operand};
                result = sum[DATA_W-1:0];
                c_out  = sum[DATA_W];
            end
            OP_SUB: begin
                result = acc - operand;
                c_out  = (acc < operand);
            end
            OP_AND: result = acc & operand;
            OP_OR:  result = acc | operand;
            OP_XOR: result = acc ^ operand;
            OP_NOT: result = ~acc;
            OP_SHL: begin
                result = {acc[DATA_W-2:0], 1'b0};
                c_out  = acc[DATA_W-1];
            end
            OP_SHR: begin
                result = {1'b0, acc[DATA_W-1:1]};
                c_out  = acc[0];
            end
            default: result = acc;
        endcase
    end

    assign z_out = (result == {DATA_W{1'b0}});
endmodule

// File: rtl/acc_cpu_core.sv
// Accumulator CPU core: fetch/exec/mem FSM, pc, ir, acc and C/Z flags.
module acc_cpu_core
    import cpu_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int OPC_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    acc_cpu_core_if.master    bus,
    output logic [DATA_W-1:0] acc,
    output logic [ADDR_W-1:0] pc,
    output logic              halted
);
    localparam int IW = instr_w(OPC_W, ADDR_W);

    state_t            state_r, state_nxt;
    logic [IW-1:0]     ir_r;
    logic [ADDR_W-1:0] pc_r;
    logic [DATA_W-1:0] acc_r;
    logic              c_r, z_r;

    logic [3:0]        op;
    logic [ADDR_W-1:0] opr;
    logic [DATA_W-1:0] alu_opnd, alu_res;
    logic              alu_c, alu_z;
    logic              acc_we, jump_take;
    logic              fetch_done, mem_done;

    assign op         = 4'(ir_r[IW-1 -: OPC_W]);
    assign opr        = ir_r[ADDR_W-1:0];
    assign fetch_done = (state_r == FETCH) && bus.imem_rdy;
    assign mem_done   = (state_r == MEM) && bus.dmem_rdy;
    assign alu_opnd   = (state_r == MEM) ? bus.dmem_rdata : DATA_W'(opr);

    cpu_alu #(.DATA_W(DATA_W)) u_alu (
        .op      (op),
        .acc     (acc_r),
        .operand (alu_opnd),
        .c_in    (c_r),
        .result  (alu_res),
        .c_out   (alu_c),
        .z_out   (alu_z)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= RST_S;
        end else begin
            state_r <= state_nxt;
        end
    end

    // FSM next-state logic; memory-class opcodes detour through MEM.
    always_comb begin
        state_nxt = state_r;
        case (state_r)
            RST_S: state_nxt = FETCH;
            FETCH: begin
                if (bus.imem_rdy) state_nxt = EXEC;
                else              state_nxt = FETCH;
            end
            EXEC: begin
                if (op >= OP_LDA && op <= OP_XOR) state_nxt = MEM;
                else if (op == OP_HLT)            state_nxt = HALT;
                else                              state_nxt = FETCH;
            end
            MEM: begin
                if (bus.dmem_rdy) state_nxt = FETCH;
                else              state_nxt = MEM;
            end
            HALT:    state_nxt = HALT;
            default: state_nxt = RST_S;
        endcase
    end

    // FSM outputs: requests decoded straight from the state so reset drops them at once.
    always_comb begin
        bus.imem_rd = 1'b0;
        bus.dmem_rd = 1'b0;
        bus.dmem_wr = 1'b0;
        halted      = 1'b0;
        case (state_r)
            FETCH: bus.imem_rd = 1'b1;
            MEM: begin
                bus.dmem_wr = (op == OP_STA);
                bus.dmem_rd = (op != OP_STA);
            end
            HALT:    halted = 1'b1;
            default: halted = 1'b0;
        endcase
    end

    // Decide whether this cycle writes acc/flags and whether a jump is taken.
    always_comb begin
        acc_we    = 1'b0;
        jump_take = 1'b0;
        case (state_r)
            EXEC: begin
                case (op)
                    OP_LDI, OP_NOT, OP_SHL, OP_SHR: acc_we = 1'b1;
                    OP_JMP:  jump_take = 1'b1;
                    OP_JZ:   jump_take = z_r;
                    OP_JC:   jump_take = c_r;
                    default: acc_we = 1'b0;
                endcase
            end
            MEM:     acc_we = mem_done && (op != OP_STA);
            default: acc_we = 1'b0;
        endcase
    end

    // Program counter and instruction register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_r <= {ADDR_W{1'b0}};
            ir_r <= {IW{1'b0}};
        end else if (fetch_done) begin
            ir_r <= bus.imem_data;
            pc_r <= pc_r + {{(ADDR_W-1){1'b0}}, 1'b1};
        end else if (jump_take) begin
            pc_r <= opr;
        end
    end

    // Accumulator and flags; the ALU passes C through for ops that leave it alone.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_r <= {DATA_W{1'b0}};
            c_r   <= 1'b0;
            z_r   <= 1'b0;
        end else if (acc_we) begin
            acc_r <= alu_res;
            c_r   <= alu_c;
            z_r   <= alu_z;
        end
    end

    assign bus.imem_addr  = pc_r;
    assign bus.dmem_addr  = opr;
    assign bus.dmem_wdata = acc_r;
    assign acc            = acc_r;
    assign pc             = pc_r;
endmodule

// File: tb/tb_acc_cpu_core.sv
// Directed bench for acc_cpu_core with wait-state ROM/RAM models.
module tb_acc_cpu_core;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] acc;
    logic [3:0] pc;
    logic       halted;

    int checks = 0;
    int errors = 0;

    logic [7:0] rom [16];
    logic [7:0] ram [16];
    int iwait = 0, dwait = 0;
    int icnt = 0, dcnt = 0;
    logic mon_en = 1'b0;

    acc_cpu_core_if #(.DATA_W(8), .ADDR_W(4), .OPC_W(4)) bus ();

    acc_cpu_core #(.DATA_W(8), .ADDR_W(4), .OPC_W(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus),
        .acc    (acc),
        .pc     (pc),
        .halted (halted)
    );

    always #5 clk = ~clk;

    // Memory responders: rdy rises after the configured number of wait cycles.
    always_comb begin
        bus.imem_data  = rom[bus.imem_addr];
        bus.imem_rdy   = (icnt == iwait);
        bus.dmem_rdata = ram[bus.dmem_addr];
        bus.dmem_rdy   = (dcnt == dwait);
    end

    // Wait counters and RAM write port.
    always @(posedge clk) begin
        if (bus.imem_rd && !bus.imem_rdy) icnt <= icnt + 1;
        else                              icnt <= 0;
        if ((bus.dmem_rd || bus.dmem_wr) && !bus.dmem_rdy) dcnt <= dcnt + 1;
        else                                               dcnt <= 0;
        if (bus.dmem_wr && bus.dmem_rdy) ram[bus.dmem_addr] = bus.dmem_wdata;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Request/address must stay put across every wait cycle.
    logic       prev_iw = 1'b0, prev_dw = 1'b0;
    logic [3:0] prev_ia, prev_da;
    logic [1:0] prev_drw;
    always @(negedge clk) begin
        if (mon_en) begin
            if (prev_iw) check("imem_hold", 32'({bus.imem_rd, bus.imem_addr}), 32'({1'b1, prev_ia}));
            if (prev_dw) check("dmem_hold", 32'({bus.dmem_rd, bus.dmem_wr, bus.dmem_addr}),
                               32'({prev_drw, prev_da}));
            prev_iw  = bus.imem_rd && !bus.imem_rdy;
            prev_ia  = bus.imem_addr;
            prev_dw  = (bus.dmem_rd || bus.dmem_wr) && !bus.dmem_rdy;
            prev_drw = {bus.dmem_rd, bus.dmem_wr};
            prev_da  = bus.dmem_addr;
        end else begin
            prev_iw = 1'b0;
            prev_dw = 1'b0;
        end
    end

    task automatic run(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 16; i++) begin
            rom[i] = 8'h00;
            ram[i] = 8'h00;
        end
    endtask

    // Assert reset, check the reset state, release on a falling edge.
    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_imem_rd", 32'(bus.imem_rd), 32'h0);
        check("rst_dmem_rd", 32'(bus.dmem_rd), 32'h0);
        check("rst_dmem_wr", 32'(bus.dmem_wr), 32'h0);
        check("rst_acc", 32'(acc), 32'h0);
        check("rst_pc", 32'(pc), 32'h0);
        check("rst_halted", 32'(halted), 32'h0);
        check("rst_state", 32'(dut.state_r), 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_idle_cycle", 32'(bus.imem_rd), 32'h0);
    endtask

    initial begin
        // Test 1: zero-wait basic program
        clear_mem();
        rom[0] = 8'h85; rom[1] = 8'h33; rom[2] = 8'h24; rom[3] = 8'hF0;
        ram[3] = 8'h0A;
        reset_dut();
        run(1);
        check("t1_first_fetch", 32'({bus.imem_rd, bus.imem_addr}), 32'h10);
        run(9);
        check("t1_not_halted", 32'(halted), 32'h0);
        run(1);
        check("t1_halted", 32'(halted), 32'h1);
        check("t1_pc", 32'(pc), 32'h4);
        check("t1_acc", 32'(acc), 32'h0F);
        check("t1_ram4", 32'(ram[4]), 32'h0F);
        check("t1_z", 32'(dut.z_r), 32'h0);
        run(3);
        check("t1_frozen", 32'({halted, pc, acc, bus.imem_rd}), 32'({1'b1, 4'h4, 8'h0F, 1'b0}));

        // Test 2: same program with wait states
        clear_mem();
        rom[0] = 8'h85; rom[1] = 8'h33; rom[2] = 8'h24; rom[3] = 8'hF0;
        ram[3] = 8'h0A;
        iwait = 3; dwait = 2;
        reset_dut();
        mon_en = 1'b1;
        run(26);
        check("t2_not_halted", 32'(halted), 32'h0);
        run(1);
        mon_en = 1'b0;
        check("t2_halted", 32'(halted), 32'h1);
        check("t2_pc", 32'(pc), 32'h4);
        check("t2_acc", 32'(acc), 32'h0F);
        check("t2_ram4", 32'(ram[4]), 32'h0F);
        iwait = 0; dwait = 0;

        // Test 3: ADD carry-out, JC taken
        clear_mem();
        rom[0] = 8'h11; rom[1] = 8'h32; rom[2] = 8'hB7; rom[7] = 8'hF0;
        ram[1] = 8'hFF; ram[2] = 8'h01;
        reset_dut();
        run(7);
        check("t3_acc", 32'(acc), 32'h00);
        check("t3_z", 32'(dut.z_r), 32'h1);
        check("t3_c", 32'(dut.c_r), 32'h1);
        run(4);
        check("t3_halted", 32'(halted), 32'h1);
        check("t3_pc", 32'(pc), 32'h8);

        // Test 3 variant: JZ with Z=0 falls through
        clear_mem();
        rom[0] = 8'h81; rom[1] = 8'hA7; rom[2] = 8'hF0; rom[7] = 8'hF0;
        reset_dut();
        run(7);
        check("t3b_halted", 32'(halted), 32'h1);
        check("t3b_pc", 32'(pc), 32'h3);
        check("t3b_acc", 32'(acc), 32'h01);

        // Test 4: NOP stream, pc wraps
        clear_mem();
        reset_dut();
        run(1);
        for (int i = 0; i < 18; i++) begin
            check("t4_fetch", 32'({bus.imem_rd, bus.imem_addr}), 32'({1'b1, 4'(i % 16)}));
            run(2);
        end
        check("t4_acc", 32'(acc), 32'h0);
        check("t4_halted", 32'(halted), 32'h0);

        // Test 5: SUB borrow, SHR, ADD without carry, SHL into carry
        clear_mem();
        rom[0] = 8'h89; rom[1] = 8'h40; rom[2] = 8'hE0;
        rom[3] = 8'h32; rom[4] = 8'hD0; rom[5] = 8'hF0;
        ram[0] = 8'h0A; ram[2] = 8'h01;
        reset_dut();
        run(6);
        check("t5_sub", 32'({acc, dut.c_r, dut.z_r}), 32'({8'hFF, 1'b1, 1'b0}));
        run(2);
        check("t5_shr", 32'({acc, dut.c_r, dut.z_r}), 32'({8'h7F, 1'b1, 1'b0}));
        run(3);
        check("t5_add", 32'({acc, dut.c_r, dut.z_r}), 32'({8'h80, 1'b0, 1'b0}));
        run(2);
        check("t5_shl", 32'({acc, dut.c_r, dut.z_r}), 32'({8'h00, 1'b1, 1'b1}));
        run(2);
        check("t5_halted", 32'(halted), 32'h1);

        // Test 6: reset while STA waits in MEM
        clear_mem();
        rom[0] = 8'h85; rom[1] = 8'h27;
        ram[7] = 8'h33;
        dwait = 5;
        reset_dut();
        run(5);
        check("t6_sta_req", 32'({bus.dmem_wr, bus.dmem_rd, bus.dmem_addr, bus.dmem_wdata}),
              32'({1'b1, 1'b0, 4'h7, 8'h05}));
        run(1);
        #2;
        rst = 1'b0;
        #1;
        check("t6_wr_drop", 32'({bus.dmem_wr, bus.dmem_rd, bus.imem_rd}), 32'h0);
        check("t6_acc_rst", 32'(acc), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        check("t6_ram_kept", 32'(ram[7]), 32'h33);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("t6_idle", 32'(bus.imem_rd), 32'h0);
        run(1);
        check("t6_restart", 32'({bus.imem_rd, bus.imem_addr}), 32'h10);
        check("t6_acc", 32'(acc), 32'h0);
        check("t6_halted", 32'(halted), 32'h0);
        dwait = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
